// File: rtl/muldiv_arbiter.sv
// Two-port arbiter that time-shares one mul/div unit and short-circuits the div/rem corner cases.
// Latency: corner case accept T -> resp T+1; otherwise enable T+1, unit completion at C -> resp C+1.
// Backpressure: reqN_ready only in IDLE to one fair-arbitrated winner; a stuck unit is aborted after TIMEOUT WAIT cycles.
module muldiv_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_rs1,
    input  logic [31:0] req0_rs2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_rs1,
    input  logic [31:0] req1_rs2,
    output logic        resp0_valid,
    output logic [31:0] resp0_data,
    output logic        resp1_valid,
    output logic [31:0] resp1_data,
    output logic        unit_enable,
    output logic        unit_is_div,
    output logic        unit_s_signed,
    output logic        unit_t_signed,
    output logic [31:0] unit_s,
    output logic [31:0] unit_t,
    input  logic        unit_completed,
    input  logic [31:0] unit_lo,
    input  logic [31:0] unit_hi,
    output logic        timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_last_grant;
    logic          r_gnt;
    logic [2:0]    r_op;
    logic [31:0]   r_unit_s;
    logic [31:0]   r_unit_t;
    logic          r_is_div;
    logic          r_s_signed;
    logic          r_t_signed;
    logic [CW-1:0] r_wait_cnt;
    logic          r_timeout;
    logic [31:0]   r_resp0_data;
    logic [31:0]   r_resp1_data;

    logic          w_any;
    logic          w_gidx;
    logic          w_accept;
    logic [2:0]    w_op;
    logic [31:0]   w_rs1;
    logic [31:0]   w_rs2;
    logic          w_rs2_zero;
    logic          w_ovf;
    logic          w_special;
    logic [31:0]   w_special_data;
    logic          w_expire;
    logic          w_sel_lo;
    logic [31:0]   w_unit_result;

    // Fair arbitration: a lone requester wins, a tie goes to the port not granted last.
    assign w_any    = req0_valid | req1_valid;
    assign w_gidx   = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    assign w_accept = (r_state == S_IDLE) & w_any;

    assign req0_ready = w_accept & ~w_gidx;
    assign req1_ready = w_accept &  w_gidx;

    assign w_op  = w_gidx ? req1_op  : req0_op;
    assign w_rs1 = w_gidx ? req1_rs1 : req0_rs1;
    assign w_rs2 = w_gidx ? req1_rs2 : req0_rs2;

    assign w_rs2_zero = (w_rs2 == 32'h0);
    assign w_ovf      = (w_rs1 == 32'h8000_0000) && (w_rs2 == 32'hFFFF_FFFF);

    // Divide-by-zero and signed-overflow results are fixed by the ISA, so they never occupy the unit.
    always_comb begin
        w_special      = 1'b0;
        w_special_data = 32'h0;
        case (w_op)
            3'd4: begin
                if (w_rs2_zero) begin
                    w_special      = 1'b1;
                    w_special_data = 32'hFFFF_FFFF;
                end else if (w_ovf) begin
                    w_special      = 1'b1;
                    w_special_data = 32'h8000_0000;
                end
            end
            3'd5: begin
                if (w_rs2_zero) begin
                    w_special      = 1'b1;
                    w_special_data = 32'hFFFF_FFFF;
                end
            end
            3'd6: begin
                if (w_rs2_zero) begin
                    w_special      = 1'b1;
                    w_special_data = w_rs1;
                end else if (w_ovf) begin
                    w_special      = 1'b1;
                    w_special_data = 32'h0;
                end
            end
            3'd7: begin
                if (w_rs2_zero) begin
                    w_special      = 1'b1;
                    w_special_data = w_rs1;
                end
            end
            default: begin
            end
        endcase
    end

    // mul/div/divu take the low half (product low / quotient); everything else the high half.
    assign w_sel_lo      = (r_op == 3'd0) || (r_op == 3'd4) || (r_op == 3'd5);
    assign w_unit_result = w_sel_lo ? unit_lo : unit_hi;
    assign w_expire      = ~unit_completed && (r_wait_cnt == CNT_LAST);

    // Next-state logic; the unit start pulse is the ISSUE state itself.
    always_comb begin
        w_next      = r_state;
        unit_enable = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_special ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                unit_enable = 1'b1;
                w_next      = S_WAIT;
            end
            S_WAIT: begin
                if (unit_completed || w_expire) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch, unit mode, WAIT cycle counter and abort pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_op         <= 3'd0;
            r_unit_s     <= 32'h0;
            r_unit_t     <= 32'h0;
            r_is_div     <= 1'b0;
            r_s_signed   <= 1'b0;
            r_t_signed   <= 1'b0;
            r_wait_cnt   <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (w_accept) begin
                r_last_grant <= w_gidx;
                r_gnt        <= w_gidx;
                r_op         <= w_op;
                r_unit_s     <= w_rs1;
                r_unit_t     <= w_rs2;
                r_is_div     <= w_op[2];
                r_s_signed   <= (w_op == 3'd0) || (w_op == 3'd1) || (w_op == 3'd2) ||
                                (w_op == 3'd4) || (w_op == 3'd6);
                r_t_signed   <= (w_op == 3'd0) || (w_op == 3'd1) ||
                                (w_op == 3'd4) || (w_op == 3'd6);
            end
            if (r_state == S_ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
                if (w_expire) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    // Per-port result registers: written only when a response to that port is produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp0_data <= 32'h0;
            r_resp1_data <= 32'h0;
        end else if (w_accept && w_special) begin
            if (w_gidx) r_resp1_data <= w_special_data;
            else        r_resp0_data <= w_special_data;
        end else if (r_state == S_WAIT && unit_completed) begin
            if (r_gnt) r_resp1_data <= w_unit_result;
            else       r_resp0_data <= w_unit_result;
        end else if (r_state == S_WAIT && w_expire) begin
            if (r_gnt) r_resp1_data <= 32'h0;
            else       r_resp0_data <= 32'h0;
        end
    end

    assign resp0_valid   = (r_state == S_RESP) & ~r_gnt;
    assign resp1_valid   = (r_state == S_RESP) &  r_gnt;
    assign resp0_data    = r_resp0_data;
    assign resp1_data    = r_resp1_data;
    assign unit_s        = r_unit_s;
    assign unit_t        = r_unit_t;
    assign unit_is_div   = r_is_div;
    assign unit_s_signed = r_s_signed;
    assign unit_t_signed = r_t_signed;
    assign timeout       = r_timeout;

endmodule
